copy_arbiter: RTL and testbench

Clocked controller that shares a single two-way copy (fan-out) stage among `NUM_REQ` requesters. It round-robin arbitrates requester packets, holds the granted packet for a forward delay, and presents it on both output ports. It waits until every targeted output has accepted the packet (join semantics), then applies a backward recovery delay before the next grant. It sits in front of the NoC copy datapath and turns the CSP fork/join behaviour into a cycle-accurate valid/ready schedule.

---
 rtl/copy_arbiter.sv | 160 ++++++++++++++++
 tb/tb_copy_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/copy_arbiter.sv
// Round-robin arbiter that feeds one shared two-way copy stage: grant, forward delay, fork to both
// outputs, join on their handshakes, backward delay. Optional COPY_ARB_MASK_EN adds per-packet destination masks.
module copy_arbiter #(
  parameter int WIDTH_PACKAGE = 33,
  parameter int NUM_REQ       = 4,
  parameter int FL            = 2,
  parameter int BL            = 1,
  localparam int IDW          = $clog2(NUM_REQ)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0]               in_valid,
  output logic [NUM_REQ-1:0]               in_ready,
  input  logic [NUM_REQ*WIDTH_PACKAGE-1:0] in_data,
`ifdef COPY_ARB_MASK_EN
  input  logic [NUM_REQ*2-1:0]             in_mask,
`endif
  output logic                             out0_valid,
  input  logic                             out0_ready,
  output logic [WIDTH_PACKAGE-1:0]         out0_data,
  output logic                             out1_valid,
  input  logic                             out1_ready,
  output logic [WIDTH_PACKAGE-1:0]         out1_data,
  output logic                             busy,
  output logic [IDW-1:0]                   grant_id,
  output logic [15:0]                      pkt_count,
  output logic [1:0]                       state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
  // Valid is never withdrawn before its transfer; ready may change on any cycle.

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_FWD = 2'd1, S_SEND = 2'd2, S_BACK = 2'd3} state_t;
  typedef logic [IDW:0] idx_t;

  localparam logic [3:0]     FL_LOAD  = 4'(FL - 1);
  localparam logic [3:0]     BL_LOAD  = 4'(BL - 1);
  localparam logic [IDW-1:0] LAST_REQ = IDW'(NUM_REQ - 1);

  state_t                   state_q;
  logic [IDW-1:0]           ptr_q;
  logic [IDW-1:0]           grant_q;
  logic [WIDTH_PACKAGE-1:0] data_q;
  logic [1:0]               mask_q;
  logic [1:0]               out_valid_q;
  logic [3:0]               cnt_q;
  logic [15:0]              pkt_q;

  logic [NUM_REQ-1:0]       gnt;
  logic [IDW-1:0]           gnt_idx;
  logic                     found;
  idx_t                     idx;
  logic [WIDTH_PACKAGE-1:0] sel_data;
  logic [1:0]               sel_mask;
  logic [1:0]               out_ready;
  logic                     all_done;

  // Search starts at ptr_q and wraps, so the first valid at or after ptr_q wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    if (state_q == S_IDLE) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        idx = idx_t'(ptr_q) + idx_t'(i);
        if (idx >= idx_t'(NUM_REQ)) idx = idx - idx_t'(NUM_REQ);
        if (!found && in_valid[idx[IDW-1:0]]) begin
          found                = 1'b1;
          gnt[idx[IDW-1:0]]    = 1'b1;
          gnt_idx              = idx[IDW-1:0];
        end
      end
    end
  end

  always_comb begin
    sel_data = '0;
    sel_mask = 2'b11;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_data = in_data[i*WIDTH_PACKAGE +: WIDTH_PACKAGE];
`ifdef COPY_ARB_MASK_EN
        sel_mask = in_mask[i*2 +: 2];
`endif
      end
    end
  end

  assign out_ready = {out1_ready, out0_ready};
  // A cleared valid bit in SEND means that output is done (or was never targeted).
  assign all_done  = ~|(out_valid_q & ~out_ready);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      grant_q     <= '0;
      data_q      <= '0;
      mask_q      <= '0;
      out_valid_q <= '0;
      cnt_q       <= '0;
      pkt_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (found) begin
            data_q  <= sel_data;
            mask_q  <= sel_mask;
            grant_q <= gnt_idx;
            ptr_q   <= (gnt_idx == LAST_REQ) ? '0 : gnt_idx + 1'b1;
            if (FL > 0) begin
              state_q <= S_FWD;
              cnt_q   <= FL_LOAD;
            end else begin
              state_q     <= S_SEND;
              out_valid_q <= sel_mask;
            end
          end
        end
        S_FWD: begin
          if (cnt_q == 4'd0) begin
            state_q     <= S_SEND;
            out_valid_q <= mask_q;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_SEND: begin
          out_valid_q <= out_valid_q & ~out_ready;
          if (all_done) begin
            pkt_q       <= pkt_q + 16'd1;
            out_valid_q <= '0;
            if (BL > 0) begin
              state_q <= S_BACK;
              cnt_q   <= BL_LOAD;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        default: begin
          if (cnt_q == 4'd0) state_q <= S_IDLE;
          else cnt_q <= cnt_q - 4'd1;
        end
      endcase
    end
  end

  assign in_ready   = gnt;
  assign out0_valid = out_valid_q[0];
  assign out1_valid = out_valid_q[1];
  assign out0_data  = data_q;
  assign out1_data  = data_q;
  assign busy       = (state_q != S_IDLE);
  assign grant_id   = grant_q;
  assign pkt_count  = pkt_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_copy_arbiter.sv
// Directed bench for copy_arbiter: reset, single packet, skewed join, reset mid-SEND,
// round robin, masks (with COPY_ARB_MASK_EN) and packet counter wrap.
module tb_copy_arbiter;
  localparam int W = 33;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [N*W-1:0] in_data;
`ifdef COPY_ARB_MASK_EN
  logic [N*2-1:0] in_mask;
`endif
  logic           out0_valid, out0_ready, out1_valid, out1_ready;
  logic [W-1:0]   out0_data, out1_data;
  logic           busy;
  logic [1:0]     grant_id;
  logic [15:0]    pkt_count;
  logic [1:0]     state_dbg;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  copy_arbiter #(.WIDTH_PACKAGE(W), .NUM_REQ(N), .FL(2), .BL(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
`ifdef COPY_ARB_MASK_EN
    .in_mask(in_mask),
`endif
    .out0_valid(out0_valid), .out0_ready(out0_ready), .out0_data(out0_data),
    .out1_valid(out1_valid), .out1_ready(out1_ready), .out1_data(out1_data),
    .busy(busy), .grant_id(grant_id), .pkt_count(pkt_count), .state_dbg(state_dbg)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic drive_req(input int r, input logic [W-1:0] d);
    in_data[r*W +: W] = d;
    in_valid          = in_valid | (N'(1) << r);
    #1;
  endtask

  initial begin
    logic [W-1:0] e;
    logic [W-1:0] pend_id;
    logic         pend;
    int           last;
    int           exp_pkt;

    rst_n      = 1'b0;
    in_valid   = '0;
    in_data    = '0;
    out0_ready = 1'b1;
    out1_ready = 1'b1;
`ifdef COPY_ARB_MASK_EN
    in_mask    = '1;
`endif
    repeat (3) next_cycle();
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_out0_valid", out0_valid, 0);
    check_eq("rst_out1_valid", out1_valid, 0);
    check_eq("rst_out0_data", out0_data, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_grant_id", grant_id, 0);
    check_eq("rst_pkt_count", pkt_count, 0);
    rst_n = 1'b1;
    next_cycle();

    // single packet, outputs always ready
    drive_req(0, 33'h1_2345_6789);
    check_eq("single_in_ready", in_ready, 4'b0001);
    next_cycle(); in_valid = '0;
    check_eq("single_busy_fwd", busy, 1);
    check_eq("single_valid_t1", out0_valid, 0);
    next_cycle();
    check_eq("single_valid_t2", {out1_valid, out0_valid}, 2'b00);
    next_cycle();
    check_eq("single_valid_t3", {out1_valid, out0_valid}, 2'b11);
    check_eq("single_out0_data", out0_data, 33'h1_2345_6789);
    check_eq("single_out1_data", out1_data, 33'h1_2345_6789);
    next_cycle();
    check_eq("single_valid_t4", {out1_valid, out0_valid}, 2'b00);
    check_eq("single_pkt_count", pkt_count, 1);
    check_eq("single_busy_back", busy, 1);
    next_cycle();
    check_eq("single_idle_t5", busy, 0);

    // join with out1 held off for 6 cycles
    out1_ready = 1'b0;
    drive_req(1, 33'h0_AAAA_5555);
    check_eq("join_in_ready", in_ready, 4'b0010);
    next_cycle(); in_valid = '0;
    next_cycle();
    next_cycle();
    for (int k = 0; k < 6; k++) begin
      check_eq("join_out1_valid", out1_valid, 1);
      check_eq("join_out1_data", out1_data, 33'h0_AAAA_5555);
      check_eq("join_out0_valid", out0_valid, (k == 0) ? 1 : 0);
      check_eq("join_busy", busy, 1);
      next_cycle();
    end
    out1_ready = 1'b1;
    check_eq("join_pkt_before", pkt_count, 1);
    next_cycle();
    check_eq("join_out1_dropped", out1_valid, 0);
    check_eq("join_state_back", state_dbg, 2'd3);
    check_eq("join_pkt_after", pkt_count, 2);
    next_cycle();
    check_eq("join_idle", busy, 0);

    // reset while both outputs are valid
    drive_req(2, 33'h1_0F0F_F0F0);
    check_eq("rstmid_in_ready", in_ready, 4'b0100);
    next_cycle(); in_valid = '0;
    next_cycle();
    next_cycle();
    check_eq("rstmid_valids", {out1_valid, out0_valid}, 2'b11);
    rst_n = 1'b0; out0_ready = 1'b0; out1_ready = 1'b0;
    next_cycle();
    check_eq("rstmid_valids_low", {out1_valid, out0_valid}, 2'b00);
    check_eq("rstmid_pkt", pkt_count, 0);
    check_eq("rstmid_busy", busy, 0);
    check_eq("rstmid_data", out0_data, 0);
    rst_n = 1'b1; out0_ready = 1'b1; out1_ready = 1'b1;

    // round robin with all requesters continuously valid
    for (int r = 0; r < N; r++) in_data[r*W +: W] = W'(33'h1_0000_0000 + r);
    in_valid = '1;
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
    exp_q.push_back(3); exp_q.push_back(0);
    last = -1; pend = 1'b0; pend_id = '0;
    for (int cyc = 0; cyc < 40 && exp_q.size() > 0; cyc++) begin
      #1;
      if (pend) begin
        check_eq("rr_grant_id", grant_id, pend_id);
        pend = 1'b0;
      end
      if (in_ready != 0) begin
        e = exp_q.pop_front();
        check_eq("rr_grant", in_ready, 64'd1 << e);
        if (last >= 0) check_eq("rr_spacing", cyc - last, 5);
        last = cyc; pend = 1'b1; pend_id = e;
      end
      @(negedge clk);
    end
    in_valid = '0;
    #1;
    if (pend) check_eq("rr_grant_id_last", grant_id, pend_id);
    check_eq("rr_all_granted", exp_q.size(), 0);
    for (int k = 0; k < 20 && busy; k++) next_cycle();
    check_eq("rr_drain", busy, 0);
    check_eq("rr_pkt_count", pkt_count, 5);
    exp_pkt = 5;

`ifdef COPY_ARB_MASK_EN
    // mask 01: only out0 is targeted
    in_mask[2*2 +: 2] = 2'b01;
    drive_req(2, 33'h0_1111_2222);
    check_eq("mask01_in_ready", in_ready, 4'b0100);
    next_cycle(); in_valid = '0;
    next_cycle();
    next_cycle();
    check_eq("mask01_valids", {out1_valid, out0_valid}, 2'b01);
    next_cycle();
    check_eq("mask01_valids_after", {out1_valid, out0_valid}, 2'b00);
    check_eq("mask01_pkt", pkt_count, 6);
    next_cycle();
    check_eq("mask01_idle", busy, 0);

    // mask 00: packet dropped
    in_mask[3*2 +: 2] = 2'b00;
    drive_req(3, 33'h0_3333_4444);
    check_eq("mask00_in_ready", in_ready, 4'b1000);
    in_valid = '0;
    for (int k = 1; k <= 4; k++) begin
      next_cycle();
      check_eq("mask00_no_valid", {out1_valid, out0_valid}, 2'b00);
      check_eq("mask00_busy", busy, 1);
    end
    check_eq("mask00_pkt", pkt_count, 7);
    next_cycle();
    check_eq("mask00_idle", busy, 0);
    in_mask = '1;
    exp_pkt = 7;
`endif

    // counter wrap
    check_eq("wrap_pre_pkt", pkt_count, exp_pkt);
    force dut.pkt_q = 16'hFFFF;
    next_cycle();
    release dut.pkt_q;
    check_eq("wrap_preload", pkt_count, 16'hFFFF);
    drive_req(1, 33'h1_FFFF_0000);
    check_eq("wrap_in_ready", in_ready, 4'b0010);
    next_cycle(); in_valid = '0;
    next_cycle();
    next_cycle();
    check_eq("wrap_hold", pkt_count, 16'hFFFF);
    next_cycle();
    check_eq("wrap_pkt_zero", pkt_count, 0);
    next_cycle();
    check_eq("wrap_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
